packet_dispatcher: RTL and testbench

- Sink-side counterpart of the HDMI data-island packet path.
- Deserializes the 32-pixel data-island bitstream delivered by the TERC4 decoder into one header and four subpackets, and checks BCH parity.
- Decodes Audio Clock Regeneration (0x01), Audio Sample (0x02) and AVI InfoFrame (0x82) packets into registered fields and a stereo sample stream for the audio output path.

---
 rtl/packet_dispatcher.sv | 266 ++++++++++++++++++++++++++
 tb/tb_packet_dispatcher.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_dispatcher.sv
// packet_dispatcher: sink-side HDMI data-island packet receiver.
// Collects the 32-pixel TERC4-decoded bitstream into a header and four subpackets, hands
// each complete packet to a decode buffer, and decodes ACR, Audio Sample and AVI InfoFrame
// packets into registered fields and a stereo sample stream.
// Build option: define PACKET_DISPATCHER_ECC_EN to enable BCH parity checking. Without it,
// the parity bits are ignored, ecc_error is tied to 0 and every complete packet is accepted.
module packet_dispatcher #(
  parameter int unsigned AUDIO_BIT_WIDTH = 24
) (
  input  logic                       clk_pixel,
  input  logic                       reset_n,
  input  logic                       island_valid,
  input  logic                       island_first,
  input  logic                       header_bit,
  input  logic [3:0]                 sub_even,
  input  logic [3:0]                 sub_odd,
  output logic                       packet_valid,
  output logic [7:0]                 packet_type,
  output logic                       ecc_error,
  output logic [19:0]                acr_n,
  output logic [19:0]                acr_cts,
  output logic                       acr_update,
  output logic [6:0]                 vic,
  output logic                       avi_update,
  output logic                       avi_checksum_error,
  output logic [AUDIO_BIT_WIDTH-1:0] audio_sample_word [1:0],
  output logic                       audio_sample_valid,
  output logic                       audio_frame_start
);

  typedef enum logic [1:0] {StIdle, StCheck, StEmit} state_e;

  // Collector state
  logic             col_active_q, col_active_d;
  logic [4:0]       pix_q, pix_d;
  logic [31:0]      hdr_q, hdr_d;
  logic [3:0][63:0] sub_q, sub_d;
  logic             capture;
  logic [4:0]       cap_pix;
  logic             handoff;

  // Decode buffer, loaded on the edge that captures pixel 31
  logic [23:0]      buf_hdr_q;
  logic [3:0][55:0] buf_sub_q;
  logic [223:0]     buf_flat;
  logic             buf_ok;

  // Decoder
  state_e           state_q;
  logic [3:0]       mask_q, mask_next;
  logic [1:0]       emit_idx;
  logic [3:0]       b_flags;
  logic [7:0]       avi_sum;
  logic [4:0]       pb_len;

  // Collector next state: restart on island_first, abort on a valid gap, hand off at pixel 31
  always_comb begin
    col_active_d = col_active_q;
    pix_d        = pix_q;
    hdr_d        = hdr_q;
    sub_d        = sub_q;
    capture      = 1'b0;
    cap_pix      = pix_q;
    handoff      = 1'b0;
    if (island_valid && island_first) begin
      capture      = 1'b1;
      cap_pix      = 5'd0;
      col_active_d = 1'b1;
      pix_d        = 5'd1;
    end else if (island_valid && col_active_q) begin
      capture = 1'b1;
      if (pix_q == 5'd31) begin
        handoff      = 1'b1;
        col_active_d = 1'b0;
        pix_d        = 5'd0;
      end else begin
        pix_d = pix_q + 5'd1;
      end
    end else if (!island_valid) begin
      col_active_d = 1'b0;
      pix_d        = 5'd0;
    end
    if (capture) begin
      hdr_d[cap_pix] = header_bit;
      for (int i = 0; i < 4; i++) begin
        sub_d[i][{cap_pix, 1'b0}] = sub_even[i];
        sub_d[i][{cap_pix, 1'b1}] = sub_odd[i];
      end
    end
  end

  // Collector registers
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      col_active_q <= 1'b0;
      pix_q        <= 5'd0;
      hdr_q        <= '0;
      sub_q        <= '0;
    end else begin
      col_active_q <= col_active_d;
      pix_q        <= pix_d;
      hdr_q        <= hdr_d;
      sub_q        <= sub_d;
    end
  end

`ifdef PACKET_DISPATCHER_ECC_EN
  function automatic logic [7:0] bch_step(input logic [7:0] p, input logic d);
    return {1'b0, p[7:1]} ^ ((p[0] ^ d) ? 8'h83 : 8'h00);
  endfunction

  logic [7:0]      par_hdr_q, par_hdr_d;
  logic [3:0][7:0] par_sub_q, par_sub_d;
  logic            parity_ok;
  logic            buf_ok_q;

  // Serial BCH over data bits only; pixel 0 always restarts from a cleared register
  always_comb begin
    par_hdr_d = par_hdr_q;
    par_sub_d = par_sub_q;
    parity_ok = (hdr_d[31:24] == par_hdr_q);
    if (capture && (cap_pix < 5'd24)) begin
      par_hdr_d = bch_step((cap_pix == 5'd0) ? 8'h00 : par_hdr_q, header_bit);
    end
    for (int i = 0; i < 4; i++) begin
      if (capture && (cap_pix < 5'd28)) begin
        par_sub_d[i] = bch_step(bch_step((cap_pix == 5'd0) ? 8'h00 : par_sub_q[i],
                                         sub_even[i]), sub_odd[i]);
      end
      parity_ok = parity_ok && (sub_d[i][63:56] == par_sub_q[i]);
    end
  end

  // Parity accumulators and the parity verdict travelling with the decode buffer
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      par_hdr_q <= '0;
      par_sub_q <= '0;
      buf_ok_q  <= 1'b0;
    end else begin
      par_hdr_q <= par_hdr_d;
      par_sub_q <= par_sub_d;
      if (handoff) buf_ok_q <= parity_ok;
    end
  end

  assign buf_ok = buf_ok_q;
`else
  assign buf_ok    = 1'b1;
  assign ecc_error = 1'b0;
`endif

  // Decode buffer: lets the next packet be collected while this one is decoded
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      buf_hdr_q <= '0;
      buf_sub_q <= '0;
    end else if (handoff) begin
      buf_hdr_q <= hdr_d[23:0];
      for (int i = 0; i < 4; i++) buf_sub_q[i] <= sub_d[i][55:0];
    end
  end

  // PB n sits in subpacket n/7, byte n%7, which is byte n of the flattened buffer
  assign buf_flat = buf_sub_q;
  assign pb_len   = buf_hdr_q[20:16];
  assign b_flags  = buf_hdr_q[23:20];

  // AVI checksum over the header and PB0..PB(length); bytes past PB27 do not exist
  always_comb begin
    avi_sum = buf_hdr_q[7:0] + buf_hdr_q[15:8] + buf_hdr_q[23:16];
    for (int n = 0; n < 28; n++) begin
      if (n <= int'(pb_len)) avi_sum = avi_sum + buf_flat[8*n +: 8];
    end
  end

  // Lowest still-pending present subpacket is emitted next
  always_comb begin
    emit_idx = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      if (mask_q[j]) emit_idx = 2'(j);
    end
    mask_next = mask_q & ~(4'b0001 << emit_idx);
  end

  // Decoder FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q              <= StIdle;
      mask_q               <= 4'd0;
      packet_valid         <= 1'b0;
      packet_type          <= 8'd0;
`ifdef PACKET_DISPATCHER_ECC_EN
      ecc_error            <= 1'b0;
`endif
      acr_n                <= 20'd0;
      acr_cts              <= 20'd0;
      acr_update           <= 1'b0;
      vic                  <= 7'd0;
      avi_update           <= 1'b0;
      avi_checksum_error   <= 1'b0;
      audio_sample_word[0] <= '0;
      audio_sample_word[1] <= '0;
      audio_sample_valid   <= 1'b0;
      audio_frame_start    <= 1'b0;
    end else begin
      packet_valid       <= 1'b0;
`ifdef PACKET_DISPATCHER_ECC_EN
      ecc_error          <= 1'b0;
`endif
      acr_update         <= 1'b0;
      avi_update         <= 1'b0;
      avi_checksum_error <= 1'b0;
      audio_sample_valid <= 1'b0;
      audio_frame_start  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (handoff) state_q <= StCheck;
        end
        StCheck: begin
          state_q <= StIdle;
          if (!buf_ok) begin
`ifdef PACKET_DISPATCHER_ECC_EN
            ecc_error <= 1'b1;
`endif
          end else begin
            packet_valid <= 1'b1;
            packet_type  <= buf_hdr_q[7:0];
            case (buf_hdr_q[7:0])
              8'h01: begin
                acr_cts    <= {buf_sub_q[0][11:8], buf_sub_q[0][23:16], buf_sub_q[0][31:24]};
                acr_n      <= {buf_sub_q[0][35:32], buf_sub_q[0][47:40], buf_sub_q[0][55:48]};
                acr_update <= 1'b1;
              end
              8'h82: begin
                if (avi_sum == 8'd0) begin
                  vic        <= buf_flat[38:32];
                  avi_update <= 1'b1;
                end else begin
                  avi_checksum_error <= 1'b1;
                end
              end
              8'h02: begin
                if (|buf_hdr_q[11:8]) begin
                  mask_q  <= buf_hdr_q[11:8];
                  state_q <= StEmit;
                end
              end
              default: ;
            endcase
          end
        end
        StEmit: begin
          audio_sample_valid   <= 1'b1;
          audio_sample_word[0] <= buf_sub_q[emit_idx][23 -: AUDIO_BIT_WIDTH];
          audio_sample_word[1] <= buf_sub_q[emit_idx][47 -: AUDIO_BIT_WIDTH];
          audio_frame_start    <= b_flags[emit_idx];
          mask_q               <= mask_next;
          if (mask_next == 4'd0) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_dispatcher.sv
// Bench for packet_dispatcher: directed packets, a packet-level model and a per-cycle compare.
module tb_packet_dispatcher;

  localparam int W = 16;
`ifdef PACKET_DISPATCHER_ECC_EN
  localparam bit ECC_ON = 1'b1;
`else
  localparam bit ECC_ON = 1'b0;
`endif

  localparam int K_PV  = 0;
  localparam int K_ECC = 1;
  localparam int K_ACR = 2;
  localparam int K_AVI = 3;
  localparam int K_CKS = 4;
  localparam int K_AUD = 5;

  logic         clk_pixel = 1'b0;
  logic         reset_n;
  logic         island_valid, island_first, header_bit;
  logic [3:0]   sub_even, sub_odd;
  logic         packet_valid, ecc_error, acr_update, avi_update, avi_checksum_error;
  logic [7:0]   packet_type;
  logic [19:0]  acr_n, acr_cts;
  logic [6:0]   vic;
  logic [W-1:0] audio_sample_word [1:0];
  logic         audio_sample_valid, audio_frame_start;

  packet_dispatcher #(.AUDIO_BIT_WIDTH(W)) dut (
    .clk_pixel          (clk_pixel),
    .reset_n            (reset_n),
    .island_valid       (island_valid),
    .island_first       (island_first),
    .header_bit         (header_bit),
    .sub_even           (sub_even),
    .sub_odd            (sub_odd),
    .packet_valid       (packet_valid),
    .packet_type        (packet_type),
    .ecc_error          (ecc_error),
    .acr_n              (acr_n),
    .acr_cts            (acr_cts),
    .acr_update         (acr_update),
    .vic                (vic),
    .avi_update         (avi_update),
    .avi_checksum_error (avi_checksum_error),
    .audio_sample_word  (audio_sample_word),
    .audio_sample_valid (audio_sample_valid),
    .audio_frame_start  (audio_frame_start)
  );

  always #5 clk_pixel = ~clk_pixel;

  int cyc = 0;
  always @(posedge clk_pixel) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int last_e;

  typedef struct {
    int          cyc;
    int          kind;
    int unsigned a;
    int unsigned b;
    int unsigned c;
  } ev_t;
  ev_t evq[$];

  // Model state: persistent fields plus this cycle's expected pulses
  int unsigned m_type, m_acr_n, m_acr_cts, m_vic, m_w0, m_w1;
  int unsigned m_pv, m_ecc, m_acru, m_aviu, m_cks, m_asv, m_afs;

  logic [3:0][55:0] d;
  logic [31:0]      h;
  logic [3:0][63:0] s;
  logic [7:0]       pb [28];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] bch(input logic [63:0] bits, input int n);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < n; k++) p = {1'b0, p[7:1]} ^ ((p[0] ^ bits[k]) ? 8'h83 : 8'h00);
    return p;
  endfunction

  function automatic int unsigned byte_of(input logic [63:0] x, input int k);
    return {24'd0, x[8*k +: 8]};
  endfunction

  task automatic push_ev(input int c, input int kind, input int unsigned a, input int unsigned b,
                         input int unsigned fs);
    ev_t e;
    e.cyc = c; e.kind = kind; e.a = a; e.b = b; e.c = fs;
    evq.push_back(e);
  endtask

  task automatic model_clear();
    evq.delete();
    m_type = 0; m_acr_n = 0; m_acr_cts = 0; m_vic = 0; m_w0 = 0; m_w1 = 0;
  endtask

  // Packet-level expectations from the received header and subpackets
  task automatic model_packet(input logic [31:0] hh, input logic [3:0][63:0] ss, input int e);
    bit          ok;
    int unsigned sum, pbv;
    int          idx, len;
    ok = 1'b1;
    if (ECC_ON) begin
      if (bch({32'd0, hh}, 24) != hh[31:24]) ok = 1'b0;
      for (int i = 0; i < 4; i++) if (bch(ss[i], 56) != ss[i][63:56]) ok = 1'b0;
    end
    if (!ok) begin
      push_ev(e + 1, K_ECC, 0, 0, 0);
    end else begin
      push_ev(e + 1, K_PV, {24'd0, hh[7:0]}, 0, 0);
      if (hh[7:0] == 8'h01) begin
        push_ev(e + 1, K_ACR,
                ((byte_of(ss[0], 4) & 32'hF) << 16) | (byte_of(ss[0], 5) << 8) | byte_of(ss[0], 6),
                ((byte_of(ss[0], 1) & 32'hF) << 16) | (byte_of(ss[0], 2) << 8) | byte_of(ss[0], 3),
                0);
      end else if (hh[7:0] == 8'h82) begin
        sum = {24'd0, hh[7:0]} + {24'd0, hh[15:8]} + {24'd0, hh[23:16]};
        len = int'(hh[20:16]);
        for (int n = 0; n <= len; n++) begin
          pbv = (n < 28) ? byte_of(ss[n / 7], n % 7) : 0;
          sum += pbv;
        end
        if (sum % 256 == 0) push_ev(e + 1, K_AVI, byte_of(ss[0], 4) & 32'h7F, 0, 0);
        else push_ev(e + 1, K_CKS, 0, 0, 0);
      end else if (hh[7:0] == 8'h02) begin
        idx = 0;
        for (int j = 0; j < 4; j++) begin
          if (hh[8 + j]) begin
            push_ev(e + 2 + idx, K_AUD, {8'd0, ss[j][23:0]} >> (24 - W),
                    {8'd0, ss[j][47:24]} >> (24 - W), {31'd0, hh[20 + j]});
            idx++;
          end
        end
      end
    end
  endtask

  // Per-cycle compare of every output against the model
  always @(negedge clk_pixel) begin
    m_pv = 0; m_ecc = 0; m_acru = 0; m_aviu = 0; m_cks = 0; m_asv = 0; m_afs = 0;
    for (int k = evq.size() - 1; k >= 0; k--) begin
      if (evq[k].cyc == cyc) begin
        case (evq[k].kind)
          K_PV:  begin m_pv = 1; m_type = evq[k].a; end
          K_ECC: m_ecc = 1;
          K_ACR: begin m_acru = 1; m_acr_n = evq[k].a; m_acr_cts = evq[k].b; end
          K_AVI: begin m_aviu = 1; m_vic = evq[k].a; end
          K_CKS: m_cks = 1;
          default: begin m_asv = 1; m_w0 = evq[k].a; m_w1 = evq[k].b; m_afs = evq[k].c; end
        endcase
        evq.delete(k);
      end
    end
    chk("packet_valid", 32'(packet_valid), m_pv);
    chk("packet_type", 32'(packet_type), m_type);
    chk("ecc_error", 32'(ecc_error), m_ecc);
    chk("acr_update", 32'(acr_update), m_acru);
    chk("acr_n", 32'(acr_n), m_acr_n);
    chk("acr_cts", 32'(acr_cts), m_acr_cts);
    chk("avi_update", 32'(avi_update), m_aviu);
    chk("vic", 32'(vic), m_vic);
    chk("avi_checksum_error", 32'(avi_checksum_error), m_cks);
    chk("audio_sample_valid", 32'(audio_sample_valid), m_asv);
    if (m_asv != 0) begin
      chk("audio_left", 32'(audio_sample_word[0]), m_w0);
      chk("audio_right", 32'(audio_sample_word[1]), m_w1);
      chk("audio_frame_start", 32'(audio_frame_start), m_afs);
    end
  end

  task automatic make_pkt(input logic [7:0] hb0, input logic [7:0] hb1, input logic [7:0] hb2,
                          input logic [3:0][55:0] dd, output logic [31:0] ho,
                          output logic [3:0][63:0] so);
    logic [23:0] hd;
    hd = {hb2, hb1, hb0};
    ho = {bch({40'd0, hd}, 24), hd};
    for (int i = 0; i < 4; i++) so[i] = {bch({8'd0, dd[i]}, 56), dd[i]};
  endtask

  task automatic drive_pixels(input logic [31:0] hh, input logic [3:0][63:0] ss, input int lo,
                              input int hi, input bit give_first);
    for (int p = lo; p <= hi; p++) begin
      @(negedge clk_pixel);
      island_valid = 1'b1;
      island_first = give_first && (p == lo);
      header_bit   = hh[p];
      for (int i = 0; i < 4; i++) begin
        sub_even[i] = ss[i][2*p];
        sub_odd[i]  = ss[i][2*p + 1];
      end
    end
  endtask

  task automatic send_packet(input logic [31:0] hh, input logic [3:0][63:0] ss);
    drive_pixels(hh, ss, 0, 31, 1'b1);
    @(posedge clk_pixel);
    #1;
    island_valid = 1'b0;
    island_first = 1'b0;
    last_e = cyc;
    model_packet(hh, ss, last_e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_pixel);
      island_valid = 1'b0;
      island_first = 1'b0;
    end
  endtask

  task automatic at_cycle(input int c);
    do @(negedge clk_pixel); while (cyc < c);
  endtask

  task automatic acr_data();
    for (int i = 0; i < 4; i++) d[i] = {8'h00, 8'h18, 8'h00, 8'h0A, 8'h22, 8'h01, 8'h00};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; island_valid = 1'b0; island_first = 1'b0; header_bit = 1'b0;
    sub_even = 4'd0; sub_odd = 4'd0;
    model_clear();
    repeat (3) @(negedge clk_pixel);
    #2 reset_n = 1'b1;
    idle(3);

    // ACR: N=6144, CTS=74250
    acr_data();
    make_pkt(8'h01, 8'h00, 8'h00, d, h, s);
    send_packet(h, s);
    at_cycle(last_e + 1);
    chk("lit_acr_update", 32'(acr_update), 1);
    chk("lit_acr_n", 32'(acr_n), 32'h01800);
    chk("lit_acr_cts", 32'(acr_cts), 32'h1220A);
    idle(2);

    // Audio, all four subpackets, B flag on the first only
    for (int i = 0; i < 4; i++) d[i] = {8'h00, 24'h123456, 24'hABCDEF};
    make_pkt(8'h02, 8'h0F, 8'h10, d, h, s);
    send_packet(h, s);
    at_cycle(last_e + 2);
    chk("lit_aud_valid0", 32'(audio_sample_valid), 1);
    chk("lit_aud_left", 32'(audio_sample_word[0]), 32'hABCD);
    chk("lit_aud_right", 32'(audio_sample_word[1]), 32'h1234);
    chk("lit_aud_fs0", 32'(audio_frame_start), 1);
    at_cycle(last_e + 3);
    chk("lit_aud_fs1", 32'(audio_frame_start), 0);
    at_cycle(last_e + 5);
    chk("lit_aud_valid3", 32'(audio_sample_valid), 1);
    at_cycle(last_e + 6);
    chk("lit_aud_valid4", 32'(audio_sample_valid), 0);
    idle(2);

    // Audio with HB1=0x05 followed back-to-back by AVI packets
    for (int i = 0; i < 4; i++) begin
      d[i] = {8'h00, 24'h200000 * 24'(i + 1) + 24'h010203, 24'h100000 * 24'(i + 1) + 24'h0A0B0C};
    end
    make_pkt(8'h02, 8'h05, 8'h40, d, h, s);
    send_packet(h, s);

    for (int n = 0; n < 28; n++) pb[n] = 8'h00;
    pb[0] = 8'h37; pb[1] = 8'h10; pb[2] = 8'h18; pb[4] = 8'h10;
    for (int n = 0; n < 28; n++) d[n / 7][8 * (n % 7) +: 8] = pb[n];
    make_pkt(8'h82, 8'h02, 8'h0D, d, h, s);
    send_packet(h, s);
    at_cycle(last_e + 1);
    chk("lit_avi_update", 32'(avi_update), 1);
    chk("lit_vic", 32'(vic), 16);

    d[0][7:0] = 8'h38;
    make_pkt(8'h82, 8'h02, 8'h0D, d, h, s);
    send_packet(h, s);
    at_cycle(last_e + 1);
    chk("lit_avi_cks_err", 32'(avi_checksum_error), 1);
    chk("lit_vic_kept", 32'(vic), 16);
    idle(2);

    // Header bit 5 flipped after parity generation
    acr_data();
    make_pkt(8'h01, 8'h00, 8'h00, d, h, s);
    h[5] = ~h[5];
    send_packet(h, s);
    at_cycle(last_e + 1);
    chk("lit_flip_ecc_error", 32'(ecc_error), 32'(ECC_ON));
    chk("lit_flip_packet_valid", 32'(packet_valid), 32'(!ECC_ON));
    idle(2);

    // Restart at pixel 17 with a null packet
    acr_data();
    make_pkt(8'h01, 8'h00, 8'h00, d, h, s);
    drive_pixels(h, s, 0, 16, 1'b1);
    d = '0;
    make_pkt(8'h00, 8'h00, 8'h00, d, h, s);
    send_packet(h, s);
    at_cycle(last_e + 1);
    chk("lit_null_pv", 32'(packet_valid), 1);
    chk("lit_null_type", 32'(packet_type), 0);
    idle(2);

    // Valid gap mid-packet, then the tail without island_first: nothing accepted
    acr_data();
    make_pkt(8'h01, 8'h00, 8'h00, d, h, s);
    drive_pixels(h, s, 0, 19, 1'b1);
    idle(3);
    drive_pixels(h, s, 20, 31, 1'b0);
    idle(6);

    // Unknown type and audio with no present samples
    make_pkt(8'h03, 8'h00, 8'h00, d, h, s);
    send_packet(h, s);
    make_pkt(8'h02, 8'h00, 8'hF0, d, h, s);
    send_packet(h, s);
    idle(8);

    // Reset in the middle of a packet
    make_pkt(8'h01, 8'h00, 8'h00, d, h, s);
    drive_pixels(h, s, 0, 9, 1'b1);
    #2;
    reset_n = 1'b0;
    island_valid = 1'b0;
    model_clear();
    #1;
    chk("lit_rst_acr_n", 32'(acr_n), 0);
    chk("lit_rst_vic", 32'(vic), 0);
    chk("lit_rst_type", 32'(packet_type), 0);
    chk("lit_rst_words", 32'(audio_sample_word[0]) | 32'(audio_sample_word[1]), 0);
    idle(3);
    #2 reset_n = 1'b1;
    idle(2);
    acr_data();
    make_pkt(8'h01, 8'h00, 8'h00, d, h, s);
    send_packet(h, s);
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
